// File: rtl/instr_decode_ctrl.sv
// Purpose: registered MIPS instruction decoder; one-hot ibus plus memory-stage controls.
// Latency: 1 cycle from instruc sampled at a rising edge to registered outputs.
// Backpressure: en=0 holds every output (stall); flush=1 clears to nop and overrides en.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (outputs cleared while low)
//   en, flush       capture enable and synchronous clear (flush wins)
//   instruc         32-bit instruction word of this pipeline stage
//   ibus            [52:0] one-hot instruction, [53] load, [54] store, [55] reserved
//   mem_write, is_byte, is_half, is_unsigned_ld, pass_apc, is_mtc0, is_mfc0
//                   memory-stage controls derived from the same decode
module instr_decode_ctrl #(
  parameter int NUM_OF_I = 55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [31:0]       instruc,
  output logic [NUM_OF_I:0] ibus,
  output logic              mem_write,
  output logic              is_byte,
  output logic              is_half,
  output logic              is_unsigned_ld,
  output logic              pass_apc,
  output logic              is_mtc0,
  output logic              is_mfc0
);

  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [5:0]        funct;
  logic [52:0]       hit;
  logic [NUM_OF_I:0] ibus_d;

  assign op    = instruc[31:26];
  assign rs    = instruc[25:21];
  assign rt    = instruc[20:16];
  assign funct = instruc[5:0];

  always_comb begin
    hit = '0;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000: hit[0]  = 1'b1;
        6'b100001: hit[1]  = 1'b1;
        6'b100010: hit[2]  = 1'b1;
        6'b100011: hit[3]  = 1'b1;
        6'b100100: hit[4]  = 1'b1;
        6'b100101: hit[5]  = 1'b1;
        6'b100110: hit[6]  = 1'b1;
        6'b100111: hit[7]  = 1'b1;
        6'b101010: hit[8]  = 1'b1;
        6'b101011: hit[9]  = 1'b1;
        // The all-zero word is the canonical nop and decodes to nothing.
        6'b000000: hit[10] = (instruc != 32'h0);
        6'b000010: hit[11] = 1'b1;
        6'b000011: hit[12] = 1'b1;
        6'b000100: hit[13] = 1'b1;
        6'b000110: hit[14] = 1'b1;
        6'b000111: hit[15] = 1'b1;
        6'b001000: hit[16] = 1'b1;
        6'b001001: hit[17] = 1'b1;
        6'b010000: hit[18] = 1'b1;
        6'b010001: hit[19] = 1'b1;
        6'b010010: hit[20] = 1'b1;
        6'b010011: hit[21] = 1'b1;
        6'b011000: hit[22] = 1'b1;
        6'b011001: hit[23] = 1'b1;
        6'b011010: hit[24] = 1'b1;
        6'b011011: hit[25] = 1'b1;
        default: ;
      endcase
    end
    case (op)
      6'b001000: hit[26] = 1'b1;
      6'b001001: hit[27] = 1'b1;
      6'b001010: hit[28] = 1'b1;
      6'b001011: hit[29] = 1'b1;
      6'b001100: hit[30] = 1'b1;
      6'b001101: hit[31] = 1'b1;
      6'b001110: hit[32] = 1'b1;
      6'b001111: hit[33] = 1'b1;
      6'b100000: hit[34] = 1'b1;
      6'b100100: hit[35] = 1'b1;
      6'b100001: hit[36] = 1'b1;
      6'b100101: hit[37] = 1'b1;
      6'b100011: hit[38] = 1'b1;
      6'b101000: hit[39] = 1'b1;
      6'b101001: hit[40] = 1'b1;
      6'b101011: hit[41] = 1'b1;
      6'b000100: hit[42] = 1'b1;
      6'b000101: hit[43] = 1'b1;
      6'b000110: hit[44] = 1'b1;
      6'b000111: hit[45] = 1'b1;
      // REGIMM: rt selects the branch flavour; other rt values are reserved.
      6'b000001: begin
        hit[46] = (rt == 5'd0);
        hit[47] = (rt == 5'd1);
      end
      6'b000010: hit[48] = 1'b1;
      6'b000011: hit[49] = 1'b1;
      // COP0: rs selects move direction; eret is matched on the full word below.
      6'b010000: begin
        hit[50] = (rs == 5'b00000);
        hit[51] = (rs == 5'b00100);
      end
      default: ;
    endcase
    hit[52] = (instruc == 32'h4200_0018);
  end

  assign ibus_d = {(instruc != 32'h0) && (hit == '0),  // reserved instruction
                   |hit[41:39],                        // store group
                   |hit[38:34],                        // load group
                   hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus           <= '0;
      mem_write      <= 1'b0;
      is_byte        <= 1'b0;
      is_half        <= 1'b0;
      is_unsigned_ld <= 1'b0;
      pass_apc       <= 1'b0;
      is_mtc0        <= 1'b0;
      is_mfc0        <= 1'b0;
    end else if (flush) begin
      ibus           <= '0;
      mem_write      <= 1'b0;
      is_byte        <= 1'b0;
      is_half        <= 1'b0;
      is_unsigned_ld <= 1'b0;
      pass_apc       <= 1'b0;
      is_mtc0        <= 1'b0;
      is_mfc0        <= 1'b0;
    end else if (en) begin
      ibus           <= ibus_d;
      mem_write      <= hit[39] | hit[40] | hit[41];
      is_byte        <= hit[34] | hit[35] | hit[39];
      is_half        <= hit[36] | hit[37] | hit[40];
      is_unsigned_ld <= hit[35] | hit[37];
      pass_apc       <= hit[49] | hit[17];
      is_mtc0        <= hit[51];
      is_mfc0        <= hit[50];
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Purpose: self-checking bench for instr_decode_ctrl using a mask/match reference table.
// Latency: expectations are queued at each capturing edge and compared 1 time unit later.
// Backpressure: stall (en=0) and flush cases are exercised explicitly.
module tb_instr_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [31:0] instruc;
  logic [55:0] ibus;
  logic        mem_write, is_byte, is_half, is_unsigned_ld, pass_apc, is_mtc0, is_mfc0;

  int checks = 0;
  int errors = 0;

  logic [62:0] sb[$];
  logic [62:0] exp_cur;
  logic [62:0] got;
  logic [62:0] e;

  logic [5:0] funct_tab [0:25] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
    6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
    6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b010000, 6'b010001, 6'b010010,
    6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011};
  logic [5:0] op_tab [0:23] = '{
    6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110,
    6'b001111, 6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011, 6'b101000,
    6'b101001, 6'b101011, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001,
    6'b000001, 6'b000010, 6'b000011};

  instr_decode_ctrl #(.NUM_OF_I(55)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .instruc(instruc),
    .ibus(ibus), .mem_write(mem_write), .is_byte(is_byte), .is_half(is_half),
    .is_unsigned_ld(is_unsigned_ld), .pass_apc(pass_apc), .is_mtc0(is_mtc0),
    .is_mfc0(is_mfc0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mask, match} for ibus bit i
  function automatic logic [63:0] ent(input int i);
    if (i < 26)  return {32'hFC00003F, 26'b0, funct_tab[i]};
    if (i == 46) return {32'hFC1F0000, 32'h04000000};
    if (i == 47) return {32'hFC1F0000, 32'h04010000};
    if (i < 50)  return {32'hFC000000, op_tab[i-26], 26'b0};
    if (i == 50) return {32'hFFE00000, 32'h40000000};
    if (i == 51) return {32'hFFE00000, 32'h40800000};
    return {32'hFFFFFFFF, 32'h42000018};
  endfunction

  function automatic logic [62:0] model(input logic [31:0] w);
    logic [55:0] b;
    logic [63:0] mm;
    b = '0;
    for (int i = 0; i < 53; i++) begin
      mm = ent(i);
      if ((w & mm[63:32]) == mm[31:0]) b[i] = 1'b1;
    end
    if (w == 32'h0) b = '0;
    b[53] = |b[38:34];
    b[54] = |b[41:39];
    b[55] = (w != 32'h0) && (b[52:0] == '0);
    return {b, b[39] | b[40] | b[41], b[34] | b[35] | b[39], b[36] | b[37] | b[40],
            b[35] | b[37], b[49] | b[17], b[51], b[50]};
  endfunction

  function automatic logic [31:0] sweep_word(input int i);
    if (i < 26)  return {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, funct_tab[i]};
    if (i == 46) return 32'h04600010;
    if (i == 47) return 32'h04610010;
    if (i < 50)  return {op_tab[i-26], 5'd1, 5'd2, 16'h0010};
    if (i == 50) return 32'h40016000;
    if (i == 51) return 32'h40816000;
    return 32'h42000018;
  endfunction

  function automatic logic [62:0] obs();
    return {ibus, mem_write, is_byte, is_half, is_unsigned_ld, pass_apc, is_mtc0, is_mfc0};
  endfunction

  // Drive one cycle, push the expected post-edge state, then step off the edge.
  task automatic drive(input logic [31:0] w, input logic en_i, input logic fl_i);
    instruc = w;
    en      = en_i;
    flush   = fl_i;
    @(posedge clk);
    if (fl_i)      exp_cur = '0;
    else if (en_i) exp_cur = model(w);
    sb.push_back(exp_cur);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; instruc = 32'h8C010004;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 63'd0) begin
      errors++; $display("FAIL reset_hold: got %h exp 0", obs());
    end
    rst_n = 1'b1; exp_cur = '0;
    drive(32'h8C010004, 1'b1, 1'b0);
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_first_sb: got %h exp %h", got, e); end
    checks++;
    if (ibus !== ((56'd1 << 38) | (56'd1 << 53)) || mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_first_lw: got ibus=%h mw=%b exp ibus=%h mw=0",
                         ibus, mem_write, (56'd1 << 38) | (56'd1 << 53));
    end
  endtask

  task automatic test_async_reset();
    drive(32'h00221820, 1'b1, 1'b0);  // add
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL async_pre: got %h exp %h", got, e); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 63'd0) begin errors++; $display("FAIL async_clear: got %h exp 0", obs()); end
    rst_n = 1'b1; exp_cur = '0;
    drive(32'h00221820, 1'b1, 1'b0);
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e || ibus !== 56'd1) begin
      errors++; $display("FAIL async_recapture: got %h exp %h", got, e);
    end
  endtask

  task automatic test_store();
    drive(32'hA0220003, 1'b1, 1'b0);
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL store_sb: got %h exp %h", got, e); end
    checks++;
    if (ibus !== ((56'd1 << 39) | (56'd1 << 54)) || {mem_write, is_byte, is_half} !== 3'b110) begin
      errors++; $display("FAIL store_ctrl: got ibus=%h mw/byte/half=%b%b%b exp mw/byte/half=110",
                         ibus, mem_write, is_byte, is_half);
    end
  endtask

  task automatic test_link_cop0();
    logic [31:0] w [5] = '{32'h0C000010, 32'h00200809, 32'h40016000, 32'h40816000, 32'h42000018};
    logic [62:0] k [5];
    k[0] = {56'd1 << 49, 7'b0000100};
    k[1] = {56'd1 << 17, 7'b0000100};
    k[2] = {56'd1 << 50, 7'b0000001};
    k[3] = {56'd1 << 51, 7'b0000010};
    k[4] = {56'd1 << 52, 7'b0000000};
    for (int i = 0; i < 5; i++) begin
      drive(w[i], 1'b1, 1'b0);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL link_cop0_sb[%0d]: got %h exp %h", i, got, e); end
      checks++;
      if (got !== k[i]) begin errors++; $display("FAIL link_cop0_const[%0d]: got %h exp %h", i, got, k[i]); end
    end
  endtask

  task automatic test_edge_words();
    logic [31:0] w [4] = '{32'h00000000, 32'h00011080, 32'h04010003, 32'hFC000000};
    logic [55:0] k [4];
    k[0] = '0; k[1] = 56'd1 << 10; k[2] = 56'd1 << 47; k[3] = 56'd1 << 55;
    for (int i = 0; i < 4; i++) begin
      drive(w[i], 1'b1, 1'b0);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL edge_sb[%0d]: got %h exp %h", i, got, e); end
      checks++;
      if (ibus !== k[i]) begin errors++; $display("FAIL edge_ibus[%0d]: got %h exp %h", i, ibus, k[i]); end
    end
  endtask

  task automatic test_stall_flush();
    logic [62:0] held;
    drive(32'h94220002, 1'b1, 1'b0);  // lhu
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lhu_sb: got %h exp %h", got, e); end
    checks++;
    if (ibus !== ((56'd1 << 37) | (56'd1 << 53)) || {is_half, is_unsigned_ld} !== 2'b11) begin
      errors++; $display("FAIL lhu_ctrl: got ibus=%h half/uns=%b%b exp half/uns=11",
                         ibus, is_half, is_unsigned_ld);
    end
    held = got;
    drive(32'hAC220000, 1'b0, 1'b0);  // sw under stall
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e || got !== held) begin
      errors++; $display("FAIL stall_hold: got %h exp %h", got, held);
    end
    drive(32'hAC220000, 1'b0, 1'b1);  // flush with en low
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== e || got !== 63'd0) begin errors++; $display("FAIL flush_clear: got %h exp 0", got); end
    drive(32'hAC220000, 1'b1, 1'b1);  // flush beats en
    got = obs(); e = sb.pop_front(); checks++;
    if (got !== 63'd0) begin errors++; $display("FAIL flush_over_en: got %h exp 0", got); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] k;
    for (int i = 0; i < 53; i++) begin
      drive(sweep_word(i), 1'b1, 1'b0);
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL sweep_sb[%0d]: got %h exp %h", i, got, e); end
      k = 56'd1 << i;
      if (i >= 34 && i <= 38) k[53] = 1'b1;
      if (i >= 39 && i <= 41) k[54] = 1'b1;
      checks++;
      if (ibus !== k) begin errors++; $display("FAIL sweep_ibus[%0d]: got %h exp %h", i, ibus, k); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; instruc = 32'h0; exp_cur = '0;
    test_reset();
    test_async_reset();
    test_store();
    test_link_cop0();
    test_edge_words();
    test_stall_flush();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
